drs_readout_scheduler: RTL and testbench

DRS_READOUT_SCHEDULER -- requirements
Module: drs_readout_scheduler

---
 rtl/drs_readout_scheduler.sv | 137 +++++++++++++
 tb/tb_drs_readout_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/drs_readout_scheduler.sv
// Trigger acceptance and READ/ACK/HOLD sequencing for the DRS readout engine.
// Counts accepted and rejected triggers and flags stuck handshakes with a sticky timeout.
module drs_readout_scheduler #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TRIG,
    input  logic        DFIFO_PROGFULL,
    input  logic        DRS_READ_DONE,
    input  logic [7:0]  HOLDOFF,
    input  logic        CLR_ERR,
    output logic [3:0]  DRS_STATE_COM,
    output logic        BUSY,
    output logic [31:0] EVENT_CNT,
    output logic [15:0] DROP_CNT,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_ACK, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [19:0] tmo_q, tmo_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  com_q, com_d;
    logic        busy_q, busy_d;
    logic [31:0] ev_q, ev_d;
    logic [15:0] drop_q, drop_d;
    logic        err_q, err_d;

    logic        accept;
    logic        tmo_hit;
    logic        tmo_set;
    logic [7:0]  hold_load;

    assign accept    = (state_q == S_IDLE) && TRIG && ENABLE && !DFIFO_PROGFULL;
    // Counter holds cycles already spent, so this fires on the TIMEOUT_CYC-th cycle.
    assign tmo_hit   = (({1'b0, tmo_q} + 21'd1) >= {1'b0, TIMEOUT_CYC});
    assign hold_load = (HOLDOFF == 8'd0) ? 8'd0 : (HOLDOFF - 8'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            tmo_q   <= 20'd0;
            hold_q  <= 8'd0;
            com_q   <= 4'd0;
            busy_q  <= 1'b0;
            ev_q    <= 32'd0;
            drop_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            com_q   <= com_d;
            busy_q  <= busy_d;
            ev_q    <= ev_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        tmo_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_READ;
                    tmo_d   = 20'd0;
                end
            end
            S_READ: begin
                tmo_d = tmo_q + 20'd1;
                if (DRS_READ_DONE) begin
                    state_d = S_ACK;
                    tmo_d   = 20'd0;
                end else if (tmo_hit) begin
                    state_d = S_ACK;
                    tmo_d   = 20'd0;
                    tmo_set = 1'b1;
                end
            end
            S_ACK: begin
                tmo_d = tmo_q + 20'd1;
                if (!DRS_READ_DONE) begin
                    state_d = S_HOLD;
                    hold_d  = hold_load;
                end else if (tmo_hit) begin
                    state_d = S_HOLD;
                    hold_d  = hold_load;
                    tmo_set = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        com_d  = 4'd0;
        busy_d = (state_d != S_IDLE);
        if (state_d == S_READ) begin
            com_d = 4'd5;
        end else if (state_d == S_ACK) begin
            com_d = 4'd6;
        end
        ev_d   = accept ? (ev_q + 32'd1) : ev_q;
        drop_d = drop_q;
        if (TRIG && ENABLE && !accept && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        err_d = err_q;
        if (tmo_set) begin
            err_d = 1'b1;
        end else if (CLR_ERR) begin
            err_d = 1'b0;
        end
    end

    assign DRS_STATE_COM = com_q;
    assign BUSY          = busy_q;
    assign EVENT_CNT     = ev_q;
    assign DROP_CNT      = drop_q;
    assign TIMEOUT_ERR   = err_q;

endmodule

// File: tb/tb_drs_readout_scheduler.sv
// Directed bench for drs_readout_scheduler with a shortened timeout of 100 cycles.
`timescale 1ns/1ps
module tb_drs_readout_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        TRIG = 1'b0;
    logic        DFIFO_PROGFULL = 1'b0;
    logic        DRS_READ_DONE = 1'b0;
    logic [7:0]  HOLDOFF = 8'd0;
    logic        CLR_ERR = 1'b0;
    logic [3:0]  DRS_STATE_COM;
    logic        BUSY;
    logic [31:0] EVENT_CNT;
    logic [15:0] DROP_CNT;
    logic        TIMEOUT_ERR;

    int total = 0;
    int bad = 0;
    int exp_ev = 0;
    int exp_drop = 0;

    drs_readout_scheduler #(.TIMEOUT_CYC(20'd100)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIG(TRIG),
        .DFIFO_PROGFULL(DFIFO_PROGFULL), .DRS_READ_DONE(DRS_READ_DONE),
        .HOLDOFF(HOLDOFF), .CLR_ERR(CLR_ERR), .DRS_STATE_COM(DRS_STATE_COM),
        .BUSY(BUSY), .EVENT_CNT(EVENT_CNT), .DROP_CNT(DROP_CNT),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #3;
        total++; if (DRS_STATE_COM !== 4'd0) begin bad++; $display("FAIL rst_com got=%0d want=0", DRS_STATE_COM); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
        total++; if (EVENT_CNT !== 32'd0) begin bad++; $display("FAIL rst_ev got=%0d want=0", EVENT_CNT); end
        total++; if (DROP_CNT !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", DROP_CNT); end
        total++; if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", TIMEOUT_ERR); end
        tick; tick;
        RST = 1'b0;
        ENABLE = 1'b1;
        tick;
        $display("reset: com=%0d busy=%b", DRS_STATE_COM, BUSY);
    endtask

    task automatic test_nominal;
        int n;
        HOLDOFF = 8'd4;
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        total++; if (DRS_STATE_COM !== 4'd5) begin bad++; $display("FAIL nom_com5 got=%0d want=5", DRS_STATE_COM); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL nom_busy got=%b want=1", BUSY); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL nom_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        ENABLE = 1'b0;
        repeat (29) tick;
        total++; if (DRS_STATE_COM !== 4'd5) begin bad++; $display("FAIL nom_still_read got=%0d want=5", DRS_STATE_COM); end
        DRS_READ_DONE = 1'b1; tick;
        total++; if (DRS_STATE_COM !== 4'd6) begin bad++; $display("FAIL nom_com6 got=%0d want=6", DRS_STATE_COM); end
        tick; tick;
        total++; if (DRS_STATE_COM !== 4'd6) begin bad++; $display("FAIL nom_ack_hold got=%0d want=6", DRS_STATE_COM); end
        DRS_READ_DONE = 1'b0; tick;
        total++; if ({DRS_STATE_COM, BUSY} !== {4'd0, 1'b1}) begin bad++; $display("FAIL nom_hold got=com%0d/busy%b want=com0/busy1", DRS_STATE_COM, BUSY); end
        n = 0;
        while (BUSY === 1'b1 && n < 50) begin n++; tick; end
        total++; if (n != 4) begin bad++; $display("FAIL nom_hold_len got=%0d want=4", n); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL nom_ev_end got=%0d want=%0d", EVENT_CNT, exp_ev); end
        ENABLE = 1'b1;
        $display("nominal: hold=%0d ev=%0d", n, EVENT_CNT);
    endtask

    task automatic test_backpressure;
        DFIFO_PROGFULL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            TRIG = 1'b1; tick; TRIG = 1'b0;
            total++; if (DRS_STATE_COM !== 4'd0) begin bad++; $display("FAIL bp_com%0d got=%0d want=0", i, DRS_STATE_COM); end
            tick;
        end
        DFIFO_PROGFULL = 1'b0;
        exp_drop += 3;
        total++; if (DROP_CNT !== 16'(exp_drop)) begin bad++; $display("FAIL bp_drop got=%0d want=%0d", DROP_CNT, exp_drop); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL bp_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        $display("backpressure: drop=%0d ev=%0d", DROP_CNT, EVENT_CNT);
    endtask

    task automatic test_busy_reject;
        int n;
        HOLDOFF = 8'd3;
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        for (int i = 0; i < 3; i++) begin
            TRIG = 1'b1; tick; TRIG = 1'b0; tick;
        end
        total++; if (DRS_STATE_COM !== 4'd5) begin bad++; $display("FAIL busy_read got=%0d want=5", DRS_STATE_COM); end
        DRS_READ_DONE = 1'b1; tick;
        DRS_READ_DONE = 1'b0; tick;
        total++; if ({DRS_STATE_COM, BUSY} !== {4'd0, 1'b1}) begin bad++; $display("FAIL busy_hold got=com%0d/busy%b want=com0/busy1", DRS_STATE_COM, BUSY); end
        TRIG = 1'b1; tick; TRIG = 1'b0; tick;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL busy_last_hold got=%b want=1", BUSY); end
        TRIG = 1'b1; tick; TRIG = 1'b0;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", BUSY); end
        exp_drop += 5;
        total++; if (DROP_CNT !== 16'(exp_drop)) begin bad++; $display("FAIL busy_drop got=%0d want=%0d", DROP_CNT, exp_drop); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL busy_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        total++; if (DRS_STATE_COM !== 4'd5) begin bad++; $display("FAIL busy_first_accept got=%0d want=5", DRS_STATE_COM); end
        DRS_READ_DONE = 1'b1; tick;
        DRS_READ_DONE = 1'b0; tick;
        n = 0;
        while (BUSY === 1'b1 && n < 50) begin n++; tick; end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL busy_ev2 got=%0d want=%0d", EVENT_CNT, exp_ev); end
        $display("busy_reject: drop=%0d ev=%0d", DROP_CNT, EVENT_CNT);
    endtask

    task automatic test_enable_ignore;
        ENABLE = 1'b0;
        TRIG = 1'b1; tick; TRIG = 1'b0;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL en_busy got=%b want=0", BUSY); end
        total++; if ({EVENT_CNT, DROP_CNT} !== {32'(exp_ev), 16'(exp_drop)}) begin bad++; $display("FAIL en_cnt got=%0d/%0d want=%0d/%0d", EVENT_CNT, DROP_CNT, exp_ev, exp_drop); end
        ENABLE = 1'b1;
        $display("enable_ignore: ev=%0d drop=%0d", EVENT_CNT, DROP_CNT);
    endtask

    task automatic test_timeout_read;
        int n;
        HOLDOFF = 8'd0;
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        n = 0;
        while (DRS_STATE_COM === 4'd5 && n < 300) begin n++; tick; end
        total++; if (n != 100) begin bad++; $display("FAIL tor_len got=%0d want=100", n); end
        total++; if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL tor_err got=%b want=1", TIMEOUT_ERR); end
        total++; if (DRS_STATE_COM !== 4'd6) begin bad++; $display("FAIL tor_ack got=%0d want=6", DRS_STATE_COM); end
        tick;
        total++; if ({DRS_STATE_COM, BUSY} !== {4'd0, 1'b1}) begin bad++; $display("FAIL tor_hold got=com%0d/busy%b want=com0/busy1", DRS_STATE_COM, BUSY); end
        tick;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL tor_hold0 got=%b want=0", BUSY); end
        total++; if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL tor_sticky got=%b want=1", TIMEOUT_ERR); end
        CLR_ERR = 1'b1; tick; CLR_ERR = 1'b0;
        total++; if (TIMEOUT_ERR !== 1'b0) begin bad++; $display("FAIL tor_clr got=%b want=0", TIMEOUT_ERR); end
        $display("timeout_read: read_cycles=%0d", n);
    endtask

    task automatic test_timeout_ack;
        int n;
        HOLDOFF = 8'd0;
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        DRS_READ_DONE = 1'b1; tick;
        CLR_ERR = 1'b1;
        n = 0;
        while (DRS_STATE_COM === 4'd6 && n < 300) begin n++; tick; end
        total++; if (n != 100) begin bad++; $display("FAIL toa_len got=%0d want=100", n); end
        total++; if (TIMEOUT_ERR !== 1'b1) begin bad++; $display("FAIL toa_setwins got=%b want=1", TIMEOUT_ERR); end
        total++; if ({DRS_STATE_COM, BUSY} !== {4'd0, 1'b1}) begin bad++; $display("FAIL toa_hold got=com%0d/busy%b want=com0/busy1", DRS_STATE_COM, BUSY); end
        CLR_ERR = 1'b0;
        DRS_READ_DONE = 1'b0;
        tick;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL toa_idle got=%b want=0", BUSY); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL toa_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        $display("timeout_ack: ack_cycles=%0d", n);
    endtask

    task automatic test_mid_reset;
        int n;
        TRIG = 1'b1; tick; TRIG = 1'b0;
        DRS_READ_DONE = 1'b1; tick;
        total++; if (DRS_STATE_COM !== 4'd6) begin bad++; $display("FAIL mr_in_ack got=%0d want=6", DRS_STATE_COM); end
        #2 RST = 1'b1;
        #1;
        total++; if ({DRS_STATE_COM, BUSY} !== {4'd0, 1'b0}) begin bad++; $display("FAIL mr_state got=com%0d/busy%b want=com0/busy0", DRS_STATE_COM, BUSY); end
        total++; if ({EVENT_CNT, DROP_CNT, TIMEOUT_ERR} !== 49'd0) begin bad++; $display("FAIL mr_cnt got=%0d/%0d/%b want=0/0/0", EVENT_CNT, DROP_CNT, TIMEOUT_ERR); end
        DRS_READ_DONE = 1'b0;
        tick;
        RST = 1'b0;
        exp_ev = 0; exp_drop = 0;
        TRIG = 1'b1; tick; TRIG = 1'b0; exp_ev++;
        total++; if (DRS_STATE_COM !== 4'd5) begin bad++; $display("FAIL mr_accept got=%0d want=5", DRS_STATE_COM); end
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL mr_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        DRS_READ_DONE = 1'b1; tick;
        DRS_READ_DONE = 1'b0; tick;
        n = 0;
        while (BUSY === 1'b1 && n < 50) begin n++; tick; end
        $display("mid_reset: ev=%0d", EVENT_CNT);
    endtask

    task automatic test_saturation;
        DFIFO_PROGFULL = 1'b1;
        TRIG = 1'b1;
        repeat (65535) tick;
        total++; if (DROP_CNT !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffff", DROP_CNT); end
        tick;
        total++; if (DROP_CNT !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", DROP_CNT); end
        TRIG = 1'b0;
        DFIFO_PROGFULL = 1'b0;
        total++; if (EVENT_CNT !== 32'(exp_ev)) begin bad++; $display("FAIL sat_ev got=%0d want=%0d", EVENT_CNT, exp_ev); end
        $display("saturation: drop=%h", DROP_CNT);
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_backpressure;
        test_busy_reject;
        test_enable_ignore;
        test_timeout_read;
        test_timeout_ack;
        test_mid_reset;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
